// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmit serializer with one-deep sample holding register
// Optional build macro: I2S_TX_UNDERRUN_REPEAT_EN (an underrun frame repeats the last loaded pair instead of sending zeros)

module i2s_tx_serializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    main_clock,
    input  logic                    reset,
    input  logic                    bclk_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    underrun_clr,
    output logic                    AUD_DACDAT,
    output logic                    AUD_DACLRCK,
    output logic                    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CW         = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_C   = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_WIDTH);

    // bit clock synchronizer and falling-edge history
    logic bclk_sync1_q, bclk_sync2_q, bclk_hist_q;
    logic fe;

    // frame position and serial outputs
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          lrck_q, lrck_d;
    logic          dat_q, dat_d;

    // per-frame shift registers
    logic [SAMPLE_WIDTH-1:0] left_sh_q, left_sh_d;
    logic [SAMPLE_WIDTH-1:0] right_sh_q, right_sh_d;

    // one-deep holding register
    logic [SAMPLE_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [SAMPLE_WIDTH-1:0] hold_right_q, hold_right_d;
    logic                    full_q, full_d;
    logic                    ready_q, ready_d;

    // underrun tracking
    logic armed_q, armed_d;
    logic underrun_q, underrun_d;
    logic underrun_set;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    // copy of the last pair that was loaded from the holding register
    logic [SAMPLE_WIDTH-1:0] last_left_q, last_left_d;
    logic [SAMPLE_WIDTH-1:0] last_right_q, last_right_d;
`endif

    // data used when a frame starts with nothing buffered
    logic [SAMPLE_WIDTH-1:0] fill_left, fill_right;

    // frame-position decode for the bit that the next fe will present
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] slot_pos;
    logic          in_right;
    logic          data_slot;
    logic          frame_wrap;
    logic          accept;

    // bring the asynchronous bit clock into the main_clock domain
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            bclk_sync1_q <= 1'b0;
            bclk_sync2_q <= 1'b0;
            bclk_hist_q  <= 1'b0;
        end else begin
            bclk_sync1_q <= bclk_in;
            bclk_sync2_q <= bclk_sync1_q;
            bclk_hist_q  <= bclk_sync2_q;
        end
    end

    assign fe = bclk_hist_q & ~bclk_sync2_q;

    // decode where the counter lands on the next falling edge
    always_comb begin
        cnt_next   = (bit_cnt_q == CNT_MAX) ? '0 : bit_cnt_q + CW'(1);
        in_right   = (cnt_next >= SLOT_C);
        slot_pos   = in_right ? (cnt_next - SLOT_C) : cnt_next;
        data_slot  = (slot_pos != '0) && (slot_pos <= SAMPLE_C);
        frame_wrap = fe && (cnt_next == '0);
        accept     = sample_valid && ready_q;
    end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    assign fill_left  = last_left_q;
    assign fill_right = last_right_q;
`else
    assign fill_left  = '0;
    assign fill_right = '0;
`endif

    // next-state for counter, serial data, holding register and underrun flag
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        lrck_d       = lrck_q;
        dat_d        = dat_q;
        left_sh_d    = left_sh_q;
        right_sh_d   = right_sh_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        full_d       = full_q;
        armed_d      = armed_q;
        underrun_set = 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        last_left_d  = last_left_q;
        last_right_d = last_right_q;
`endif

        if (fe) begin
            bit_cnt_d = cnt_next;
            lrck_d    = in_right;
            dat_d     = 1'b0;
            if (frame_wrap) begin
                if (full_q) begin
                    left_sh_d  = hold_left_q;
                    right_sh_d = hold_right_q;
                    full_d     = 1'b0;
                    armed_d    = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    last_left_d  = hold_left_q;
                    last_right_d = hold_right_q;
`endif
                end else begin
                    left_sh_d    = fill_left;
                    right_sh_d   = fill_right;
                    underrun_set = armed_q;
                end
            end else if (data_slot) begin
                // MSB goes out first, one BCLK after the word-select change
                if (in_right) begin
                    dat_d      = right_sh_q[SAMPLE_WIDTH-1];
                    right_sh_d = {right_sh_q[SAMPLE_WIDTH-2:0], 1'b0};
                end else begin
                    dat_d     = left_sh_q[SAMPLE_WIDTH-1];
                    left_sh_d = {left_sh_q[SAMPLE_WIDTH-2:0], 1'b0};
                end
            end
        end

        // ready is low whenever full, so an accept never meets a full-register load
        if (accept) begin
            hold_left_d  = sample_left;
            hold_right_d = sample_right;
            full_d       = 1'b1;
        end

        ready_d = ~full_d;

        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // state registers; ready stays low through reset and rises on the first edge after release
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= CNT_MAX;
            lrck_q       <= 1'b1;
            dat_q        <= 1'b0;
            left_sh_q    <= '0;
            right_sh_q   <= '0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            full_q       <= 1'b0;
            ready_q      <= 1'b0;
            armed_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            lrck_q       <= lrck_d;
            dat_q        <= dat_d;
            left_sh_q    <= left_sh_d;
            right_sh_q   <= right_sh_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            full_q       <= full_d;
            ready_q      <= ready_d;
            armed_q      <= armed_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    // last successfully loaded pair, replayed on underrun
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            last_left_q  <= '0;
            last_right_q <= '0;
        end else begin
            last_left_q  <= last_left_d;
            last_right_q <= last_right_d;
        end
    end
`endif

    assign sample_ready = ready_q;
    assign AUD_DACDAT   = dat_q;
    assign AUD_DACLRCK  = lrck_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - self-checking bench for i2s_tx_serializer

module tb_i2s_tx_serializer;

    logic        main_clock = 1'b0;
    logic        reset;
    logic        bclk_in;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun_clr;
    logic        AUD_DACDAT;
    logic        AUD_DACLRCK;
    logic        underrun;

    i2s_tx_serializer #(
        .SAMPLE_WIDTH(24),
        .SLOT_WIDTH  (32)
    ) dut (
        .main_clock  (main_clock),
        .reset       (reset),
        .bclk_in     (bclk_in),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .underrun_clr(underrun_clr),
        .AUD_DACDAT  (AUD_DACDAT),
        .AUD_DACLRCK (AUD_DACLRCK),
        .underrun    (underrun)
    );

    always #5 main_clock = ~main_clock;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] exp_dat;
    } vec_t;

    localparam logic [63:0] LRCK_FRAME = 64'h00000000_FFFFFFFF;

    vec_t        tab[3];
    int          n_vec = 0;
    int          n_fail = 0;
    int          exp_cnt;
    logic [63:0] dat_cap;
    logic [63:0] lrck_cap;
    int          acc_total = 0;
    int          acc_base;
    logic [63:0] exp_under;

    always @(posedge main_clock) begin
        if (!reset && sample_valid && sample_ready) acc_total++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (bit_cnt model %0d)", name, got, exp, exp_cnt);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge main_clock);
            #2;
        end
    endtask

    // one BCLK period; fe lands on the third main_clock edge after the fall
    task automatic tick(input bit clr_at_fe);
        bclk_in = 1'b0;
        cyc(2);
        if (clr_at_fe) underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        cyc(1);
        exp_cnt = (exp_cnt + 1) % 64;
        dat_cap[63-exp_cnt]  = AUD_DACDAT;
        lrck_cap[63-exp_cnt] = AUD_DACLRCK;
        bclk_in = 1'b1;
        cyc(4);
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        bit ok;
        ok = 1'b0;
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (sample_ready) ok = 1'b1;
            cyc(1);
        end
        sample_valid = 1'b0;
        check("accept_within_budget", 64'(ok), 64'd1);
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        cyc(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tab[0] = '{24'h800001, 24'h7FFFFE, {1'b0, 24'h800001, 8'h00, 24'h7FFFFE, 7'h00}};
        tab[1] = '{24'hFFFFFF, 24'h000000, {1'b0, 24'hFFFFFF, 8'h00, 24'h000000, 7'h00}};
        tab[2] = '{24'hA5C3F0, 24'h123456, {1'b0, 24'hA5C3F0, 8'h00, 24'h123456, 7'h00}};

        reset        = 1'b1;
        bclk_in      = 1'b1;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
        underrun_clr = 1'b0;
        exp_cnt      = 63;
        dat_cap      = '0;
        lrck_cap     = '0;
        @(posedge main_clock);
        #2;
        cyc(3);

        check("reset_ready", 64'(sample_ready), 64'd0);
        check("reset_lrck", 64'(AUD_DACLRCK), 64'd1);
        check("reset_dat", 64'(AUD_DACDAT), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        reset = 1'b0;
        cyc(1);
        check("ready_after_release", 64'(sample_ready), 64'd1);

        // idle: no samples offered
        for (int i = 0; i < 70; i++) begin
            tick(1'b0);
            check("idle_dat", 64'(AUD_DACDAT), 64'd0);
            check("idle_lrck", 64'(AUD_DACLRCK), (exp_cnt >= 32) ? 64'd1 : 64'd0);
            check("idle_underrun", 64'(underrun), 64'd0);
        end
        while (exp_cnt != 63) tick(1'b0);

        // table: back-to-back frames, next pair offered right after each load
        send_pair(tab[0].l, tab[0].r);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            if (i < 2) send_pair(tab[i+1].l, tab[i+1].r);
            repeat (63) tick(1'b0);
            check("frame_dat", dat_cap, tab[i].exp_dat);
            check("frame_lrck", lrck_cap, LRCK_FRAME);
            check("frame_underrun", 64'(underrun), 64'd0);
        end

        // unfed frame after a load
        tick(1'b0);
        check("underrun_set", 64'(underrun), 64'd1);
        repeat (9) tick(1'b0);
        pulse_clr();
        check("underrun_cleared", 64'(underrun), 64'd0);
        repeat (54) tick(1'b0);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        exp_under = tab[2].exp_dat;
`else
        exp_under = 64'd0;
`endif
        check("underrun_frame_dat", dat_cap, exp_under);

        // clear coincident with a new underrun set
        tick(1'b1);
        check("set_beats_clr", 64'(underrun), 64'd1);
        cyc(2);
        check("set_beats_clr_hold", 64'(underrun), 64'd1);
        repeat (63) tick(1'b0);
        pulse_clr();
        check("underrun_cleared2", 64'(underrun), 64'd0);

        // valid held high continuously
        sample_left  = 24'h000001;
        sample_right = 24'h800000;
        sample_valid = 1'b1;
        cyc(2);
        for (int f = 0; f < 2; f++) begin
            acc_base = acc_total;
            tick(1'b0);
            repeat (31) tick(1'b0);
            check("ready_low_while_full", 64'(sample_ready), 64'd0);
            repeat (32) tick(1'b0);
            check("one_accept_per_frame", 64'(acc_total - acc_base), 64'd1);
            check("stream_underrun", 64'(underrun), 64'd0);
            check("stream_dat", dat_cap, {1'b0, 24'h000001, 8'h00, 24'h800000, 7'h00});
        end

        // reset mid-frame with a pair buffered
        tick(1'b0);
        sample_valid = 1'b0;
        while (exp_cnt != 40) tick(1'b0);
        check("buffered_before_reset", 64'(sample_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("midreset_lrck", 64'(AUD_DACLRCK), 64'd1);
        check("midreset_dat", 64'(AUD_DACDAT), 64'd0);
        check("midreset_ready", 64'(sample_ready), 64'd0);
        check("midreset_underrun", 64'(underrun), 64'd0);
        exp_cnt = 63;
        @(posedge main_clock);
        #2;
        reset = 1'b0;
        cyc(1);
        check("midreset_ready_after", 64'(sample_ready), 64'd1);
        tick(1'b0);
        check("post_reset_first_lrck", 64'(AUD_DACLRCK), 64'd0);
        check("post_reset_first_underrun", 64'(underrun), 64'd0);
        repeat (63) tick(1'b0);
        check("post_reset_frame_dat", dat_cap, 64'd0);
        check("post_reset_frame_lrck", lrck_cap, LRCK_FRAME);
        tick(1'b0);
        check("post_reset_second_wrap_underrun", 64'(underrun), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 24: bits per channel sample.
REQ-002 Parameter SLOT_WIDTH, default 32: BCLK periods per channel slot; frame = 2*SLOT_WIDTH; SLOT_WIDTH SHALL be >= SAMPLE_WIDTH+1.
REQ-003 main_clock  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 bclk_in  input  1  divided bit clock from the clock divider; asynchronous to main_clock.
REQ-006 sample_left  input  SAMPLE_WIDTH  left sample, two's complement.
REQ-007 sample_right  input  SAMPLE_WIDTH  right sample, two's complement.
REQ-008 sample_valid  input  1  sample pair offered.
REQ-009 sample_ready  output  1  holding register empty; pair accepted when sample_valid && sample_ready at a rising edge.
REQ-010 underrun_clr  input  1  single-cycle clear of underrun.
REQ-011 AUD_DACDAT  output  1  serial data to codec.
REQ-012 AUD_DACLRCK  output  1  word select; 0 = left slot, 1 = right slot.
REQ-013 underrun  output  1  sticky: frame started with no pair buffered.

Function
REQ-014 bclk_in SHALL pass a 2-flop synchronizer plus one history flop; falling-edge pulse fe asserts one cycle, 3 main_clock cycles after the physical edge.
REQ-015 Bit counter bit_cnt, width clog2(2*SLOT_WIDTH), SHALL increment on fe and wrap 2*SLOT_WIDTH-1 -> 0; no other event changes it.
REQ-016 On fe, AUD_DACLRCK SHALL register 0 for new bit_cnt < SLOT_WIDTH, else 1.
REQ-017 Slot position s = new bit_cnt mod SLOT_WIDTH; on fe AUD_DACDAT SHALL register sample bit [SAMPLE_WIDTH-s] for 1 <= s <= SAMPLE_WIDTH (MSB one BCLK after LRCK change), else 0.
REQ-018 One-deep holding register: sample_ready = not full; accept sets full; sample_ready SHALL NOT depend combinationally on sample_valid.
REQ-019 Frame load on fe with wrap to 0: if full, copy holding pair into left/right shift registers, clear full, set armed.
REQ-020 Frame load with holding empty: load zeros (see REQ-030); if armed, set underrun.
REQ-021 Load and new accept SHALL NOT coincide in one cycle (ready is low while full); an accept in the cycle after load SHALL be held for the next frame.
REQ-022 Holding register SHALL NOT change while full; sample_valid while full SHALL be ignored.
REQ-023 underrun_clr SHALL clear underrun next cycle; simultaneous set and clear: set wins.
REQ-024 Outputs SHALL change only on fe cycles (AUD_*), accept/load cycles (sample_ready), or underrun set/clear.

Reset
REQ-025 Reset assertion SHALL immediately force: bit_cnt = 2*SLOT_WIDTH-1, AUD_DACLRCK = 1, AUD_DACDAT = 0, holding empty, armed = 0, underrun = 0, shift registers 0, synchronizer flops 0.
REQ-026 sample_ready SHALL be 0 while reset is high and 1 from the first cycle after release.
REQ-027 Reset mid-frame SHALL discard holding and shift contents; after release the first fe SHALL start a new frame (bit_cnt 0, left slot).
REQ-028 No underrun SHALL be flagged before the first successful load (armed = 0).

Configuration
REQ-029 Macro I2S_TX_UNDERRUN_REPEAT_EN SHALL select underrun fill data.
REQ-030 Defined: underrun frame reloads the last successfully loaded pair (zeros if never loaded); undefined: underrun frame loads zeros. underrun flag behaviour identical both ways.

Verification
REQ-031 Reset released, no samples, 70 BCLK falls -> AUD_DACDAT constantly 0, LRCK toggles every 32 BCLKs, underrun stays 0.
REQ-032 Pair L=0x800001, R=0x7FFFFE loaded before wrap -> DACDAT after LRCK fall: 1,0...0,1 (24 bits) then 8 zeros; after LRCK rise: 0,1...1,0 then 8 zeros.
REQ-033 Valid held high continuously -> exactly one accept per frame, ready low from accept cycle to load cycle, no underrun.
REQ-034 Pair loaded, next frame unfed -> underrun = 1 at second wrap; data zeros (macro undefined) or repeated pair (macro defined); underrun_clr coincident with new underrun -> stays 1.
REQ-035 Reset pulse at bit_cnt 40 with a pair buffered -> outputs at reset values immediately, ready 1 after release, first fe gives LRCK 0, no underrun at first wrap.
